cap_settle_monitor: RTL and testbench
=====================================

Name: cap_settle_monitor

Overview:
- Downstream consumer of the RC capacitor model's real-valued output `v`.
- Contains a hysteresis (Schmitt) comparator that turns `v` into a clean digital level.
- Contains a settle-detection FSM that reports when `v` has stayed within a tolerance band of a target for N consecutive cycles, or has timed out.
- Used both in simulation and as an observer for formal/BMC runs on the RC stage.

Parameters:
- V_TARGET, 0.0, real; voltage `v` must settle to.
- EPSILON, 1e-3, real; half-width of the settle band, inclusive.
- HOLD_CYCLES, 4, int ≥1; consecutive in-band samples required to declare settled.
- TIMEOUT_CYCLES, 64, int > HOLD_CYCLES; tracking cycles allowed before timeout.
- VTH_HI, 0.6, real; comparator rising threshold.
- VTH_LO, 0.4, real; comparator falling threshold, must be < VTH_HI.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high; clears all state immediately.
- start  in  1  arm/restart settle tracking.
- v  in  real  capacitor voltage from RC stage.
- cmp_out  out  1  registered Schmitt comparator output.
- in_band  out  1  registered: |v - V_TARGET| <= EPSILON.
- busy  out  1  FSM in TRACK.
- settled  out  1  FSM in SETTLED.
- timeout  out  1  FSM in TIMEOUT.
- settle_cycles  out  16  TRACK cycles taken to settle; held while SETTLED.

Behaviour:
- Reset values: cmp_out=0, in_band=0, busy=0, settled=0, timeout=0, settle_cycles=0, FSM=IDLE, internal counters 0.
- Comparator, evaluated every edge regardless of FSM state:
  - v >= VTH_HI -> 1
  - v <= VTH_LO -> 0
  - otherwise hold
  - Latency 1 cycle.
- in_band: registered each edge, latency 1 cycle. The FSM uses the combinational in-band term `ib` computed from the current `v`, not the registered output.
- FSM states: IDLE, TRACK, SETTLED, TIMEOUT. Outputs busy/settled/timeout are decoded from the state register.
- IDLE: start=1 -> TRACK with elapsed=0, hold=0.
- TRACK, each edge:
  - elapsed_n = elapsed+1 (saturating at 16'hFFFF).
  - hold_n = ib ? hold+1 : 0.
  - If hold_n == HOLD_CYCLES -> SETTLED, settle_cycles <= elapsed_n.
  - Else if elapsed_n == TIMEOUT_CYCLES -> TIMEOUT.
  - Settle takes priority over timeout on the same edge.
  - start=1 in TRACK restarts: elapsed=0, hold=0, stays in TRACK, current sample discarded.
- SETTLED:
  - start=1 -> TRACK with counters cleared; start has priority over the band check.
  - Else if !ib -> TRACK with counters cleared and settle_cycles kept until the next settle.
  - Else stay.
- TIMEOUT: sticky; start=1 -> TRACK with counters cleared.
- Real-to-int: only comparisons on `v`; no real-valued state is stored except through the comparator hold.
- Reset mid-operation: asynchronous return to reset values; no partial update on the coincident edge.

Optional Feature:
- Macro: CAP_SETTLE_MON_FORMAL_EN.
- Defined: module contains immediate/concurrent asserts:
  - settled, timeout and busy are one-hot-or-zero.
  - settled implies settle_cycles >= HOLD_CYCLES.
  - timeout implies no settle occurred since the last start.
  - cmp_out never changes while VTH_LO < v < VTH_HI.
  - Plus one cover property on reaching SETTLED.
- Undefined: no assertions/covers emitted; functional behaviour identical.

Decomposition:
- Shared package cap_pkg:
  - state enum `settle_state_t` {IDLE, TRACK, SETTLED, TIMEOUT}.
  - Default real constants for EPSILON and thresholds.
  - CNT_W=16.
- One sub-module, schmitt_cmp (params VTH_HI, VTH_LO; ports clk, rst, v, q). Reusable by other analog-model observers.

Test Plan:
- Reset check: rst=1 with v=1.0 -> all outputs 0 and FSM=IDLE. Release rst -> cmp_out=1 after 1 edge.
- Settle: HOLD_CYCLES=4, start at edge 0, v per TRACK edge = 1.0, 0.5, 5e-4, 2e-4, 0.0, 0.0 -> settled at edge 6, settle_cycles=6, busy drops same edge.
- Timeout: TIMEOUT_CYCLES=64, v held at 0.1 after start -> timeout=1 at edge 64, stays sticky. A later start -> busy=1 next cycle, timeout=0.
- Band exit: after settled, v=0.01 for one cycle -> settled=0, busy=1 next edge. Four in-band samples -> settled again, settle_cycles=4.
- Hysteresis: v ramps 0→1.0→0 in 0.1 steps -> cmp_out rises one edge after v=0.6, falls one edge after v=0.4; no toggles between.
- Coincidence: 4th in-band sample on the same edge as elapsed hits TIMEOUT_CYCLES -> SETTLED, not TIMEOUT. rst asserted mid-TRACK -> immediate IDLE, outputs 0.

Source files
------------

// File: rtl/cap_pkg.sv
// Shared types and defaults for analog-model observers (settle monitor, comparators).
package cap_pkg;
  localparam int  CNT_W       = 16;
  localparam real EPSILON_DEF = 1e-3;
  localparam real VTH_HI_DEF  = 0.6;
  localparam real VTH_LO_DEF  = 0.4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRACK   = 2'd1,
    SETTLED = 2'd2,
    TIMEOUT = 2'd3
  } settle_state_t;
endpackage

// File: rtl/schmitt_cmp.sv
// Registered hysteresis comparator on a real-valued input; holds between thresholds.
module schmitt_cmp #(
  parameter real VTH_HI = 0.6,
  parameter real VTH_LO = 0.4
) (
  input  logic clk,
  input  logic rst,
  input  real  v,
  output logic q
);
  logic q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (v >= VTH_HI)      q_d = 1'b1;
    else if (v <= VTH_LO) q_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/cap_settle_monitor.sv
// Observer for the RC stage: Schmitt level plus settle/timeout tracking of v.
// Optional checks and a cover are compiled in with CAP_SETTLE_MON_FORMAL_EN.
module cap_settle_monitor
  import cap_pkg::*;
#(
  parameter real V_TARGET       = 0.0,
  parameter real EPSILON        = EPSILON_DEF,
  parameter int  HOLD_CYCLES    = 4,
  parameter int  TIMEOUT_CYCLES = 64,
  parameter real VTH_HI         = VTH_HI_DEF,
  parameter real VTH_LO         = VTH_LO_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  real              v,
  output logic             cmp_out,
  output logic             in_band,
  output logic             busy,
  output logic             settled,
  output logic             timeout,
  output logic [CNT_W-1:0] settle_cycles
);
  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] TMO_C  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  settle_state_t    state_q, state_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d, elapsed_n;
  logic [CNT_W-1:0] hold_q, hold_d, hold_n;
  logic [CNT_W-1:0] sc_q, sc_d;
  logic             in_band_q;
  logic             ib;

  schmitt_cmp #(.VTH_HI(VTH_HI), .VTH_LO(VTH_LO)) u_cmp (
    .clk (clk),
    .rst (rst),
    .v   (v),
    .q   (cmp_out)
  );

  // Inclusive band test on both sides of the target, from the live sample.
  assign ib = ((v - V_TARGET) <= EPSILON) && ((V_TARGET - v) <= EPSILON);

  assign elapsed_n = (elapsed_q == '1) ? elapsed_q : elapsed_q + ONE_C;
  assign hold_n    = ib ? hold_q + ONE_C : '0;

  always_comb begin
    state_d   = state_q;
    elapsed_d = elapsed_q;
    hold_d    = hold_q;
    sc_d      = sc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = TRACK;
          elapsed_d = '0;
          hold_d    = '0;
        end
      end
      TRACK: begin
        if (start) begin
          elapsed_d = '0;
          hold_d    = '0;
        end else begin
          elapsed_d = elapsed_n;
          hold_d    = hold_n;
          // Settling on the same edge as the timeout wins.
          if (hold_n == HOLD_C) begin
            state_d = SETTLED;
            sc_d    = elapsed_n;
          end else if (elapsed_n == TMO_C) begin
            state_d = TIMEOUT;
          end
        end
      end
      SETTLED: begin
        if (start || !ib) begin
          state_d   = TRACK;
          elapsed_d = '0;
          hold_d    = '0;
        end
      end
      TIMEOUT: begin
        if (start) begin
          state_d   = TRACK;
          elapsed_d = '0;
          hold_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      elapsed_q <= '0;
      hold_q    <= '0;
      sc_q      <= '0;
      in_band_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      elapsed_q <= elapsed_d;
      hold_q    <= hold_d;
      sc_q      <= sc_d;
      in_band_q <= ib;
    end
  end

  assign in_band       = in_band_q;
  assign busy          = (state_q == TRACK);
  assign settled       = (state_q == SETTLED);
  assign timeout       = (state_q == TIMEOUT);
  assign settle_cycles = sc_q;

`ifdef CAP_SETTLE_MON_FORMAL_EN
  logic settle_seen_q, mid_q, cmp_prev_q, rearm;

  // A fresh tracking window starts on any entry into TRACK or a restart inside it.
  assign rearm = (state_d == TRACK) && ((state_q != TRACK) || start);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_seen_q <= 1'b0;
      mid_q         <= 1'b0;
      cmp_prev_q    <= 1'b0;
    end else begin
      settle_seen_q <= rearm ? 1'b0 : (settle_seen_q | (state_d == SETTLED));
      mid_q         <= (v > VTH_LO) && (v < VTH_HI);
      cmp_prev_q    <= cmp_out;
    end
  end

  always_comb begin
    if (!rst) begin
      a_onehot:  assert ($onehot0({busy, settled, timeout}));
      a_sc_min:  assert (!settled || (settle_cycles >= HOLD_C));
      a_tmo:     assert (!timeout || !settle_seen_q);
      a_hyst:    assert (!mid_q || (cmp_out == cmp_prev_q));
    end
  end

  c_settled: cover property (@(posedge clk) disable iff (rst) state_q == SETTLED);
`endif
endmodule

// File: tb/tb_cap_settle_monitor.sv
// Directed plus randomized bench for cap_settle_monitor against a sample-history model.
module tb_cap_settle_monitor;
  localparam int  HOLD = 4;
  localparam int  TMO  = 64;
  localparam real VT   = 0.0;
  localparam real EPS  = 1e-3;
  localparam real VHI  = 0.6;
  localparam real VLO  = 0.4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  real         v;
  logic        cmp_out, in_band, busy, settled, timeout;
  logic [15:0] settle_cycles;

  int checks = 0;
  int errors = 0;

  cap_settle_monitor #(
    .V_TARGET(VT), .EPSILON(EPS), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO),
    .VTH_HI(VHI), .VTH_LO(VLO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .v(v),
    .cmp_out(cmp_out), .in_band(in_band), .busy(busy), .settled(settled),
    .timeout(timeout), .settle_cycles(settle_cycles)
  );

  always #5 clk = ~clk;

  // Model: the list of tracking samples since arming decides everything.
  bit m_tracking, m_settled, m_timed_out, m_cmp, m_inb;
  int m_sc;
  bit hist[$];

  function automatic bit near(real x);
    real d;
    d = x - VT;
    if (d < 0.0) d = -d;
    return d <= EPS;
  endfunction

  function automatic bit tail_settled();
    if (hist.size() < HOLD) return 1'b0;
    for (int i = hist.size() - HOLD; i < hist.size(); i++)
      if (!hist[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_tracking = 0; m_settled = 0; m_timed_out = 0;
    m_cmp = 0; m_inb = 0; m_sc = 0;
    hist.delete();
  endtask

  task automatic arm();
    m_tracking = 1; m_settled = 0; m_timed_out = 0;
    hist.delete();
  endtask

  task automatic model_edge(bit s, real x);
    bit b;
    b = near(x);
    if (x >= VHI) m_cmp = 1;
    else if (x <= VLO) m_cmp = 0;
    m_inb = b;
    if (m_tracking) begin
      if (s) arm();
      else begin
        hist.push_back(b);
        if (tail_settled()) begin
          m_tracking = 0; m_settled = 1; m_sc = hist.size();
        end else if (hist.size() == TMO) begin
          m_tracking = 0; m_timed_out = 1;
        end
      end
    end else if (m_settled) begin
      if (s || !b) arm();
    end else if (m_timed_out) begin
      if (s) arm();
    end else if (s) begin
      arm();
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".cmp_out"}, 32'(cmp_out), 32'(m_cmp));
    chk({tag, ".in_band"}, 32'(in_band), 32'(m_inb));
    chk({tag, ".busy"}, 32'(busy), 32'(m_tracking));
    chk({tag, ".settled"}, 32'(settled), 32'(m_settled));
    chk({tag, ".timeout"}, 32'(timeout), 32'(m_timed_out));
    chk({tag, ".settle_cycles"}, 32'(settle_cycles), 32'(m_sc));
  endtask

  task automatic check_zero(string tag);
    chk({tag, ".cmp_out"}, 32'(cmp_out), 32'd0);
    chk({tag, ".in_band"}, 32'(in_band), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".settled"}, 32'(settled), 32'd0);
    chk({tag, ".timeout"}, 32'(timeout), 32'd0);
    chk({tag, ".settle_cycles"}, 32'(settle_cycles), 32'd0);
  endtask

  // Drive at negedge, clock, update model, compare at the next negedge.
  task automatic step(bit s, real x, string tag);
    start = s;
    v = x;
    @(posedge clk);
    model_edge(s, x);
    @(negedge clk);
    check_all(tag);
  endtask

  real seq_settle[6] = '{1.0, 0.5, 5e-4, 2e-4, 0.0, 0.0};
  real pool[12] = '{0.0, 5e-4, -8e-4, 9e-4, 1.1e-3, -1.2e-3, 0.01, 0.3, 0.45, 0.5, 0.65, 1.0};

  initial begin
    rst = 1'b1; start = 1'b0; v = 1.0;
    model_reset();
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    step(0, 1.0, "rst_release");
    chk("rst_release.cmp_hi", 32'(cmp_out), 32'd1);

    step(1, 1.0, "settle_start");
    foreach (seq_settle[i]) step(0, seq_settle[i], "settle_seq");
    chk("settle.flag", 32'(settled), 32'd1);
    chk("settle.busy", 32'(busy), 32'd0);
    chk("settle.cycles", 32'(settle_cycles), 32'd6);

    step(0, 0.01, "band_exit");
    chk("band_exit.busy", 32'(busy), 32'd1);
    chk("band_exit.sc_kept", 32'(settle_cycles), 32'd6);
    repeat (4) step(0, 0.0, "band_resettle");
    chk("band_resettle.cycles", 32'(settle_cycles), 32'd4);

    step(1, 0.1, "tmo_start");
    repeat (TMO) step(0, 0.1, "tmo_run");
    chk("tmo.flag", 32'(timeout), 32'd1);
    repeat (3) step(0, 0.0, "tmo_sticky");
    chk("tmo.sticky", 32'(timeout), 32'd1);
    step(1, 0.1, "tmo_restart");
    chk("tmo_restart.busy", 32'(busy), 32'd1);
    chk("tmo_restart.timeout", 32'(timeout), 32'd0);

    for (int i = 0; i <= 10; i++) step(0, i / 10.0, "hyst_up");
    for (int i = 10; i >= 0; i--) step(0, i / 10.0, "hyst_down");
    chk("hyst.low", 32'(cmp_out), 32'd0);

    step(1, 0.1, "coinc_start");
    repeat (TMO - HOLD) step(0, 0.1, "coinc_out");
    repeat (HOLD) step(0, 0.0, "coinc_in");
    chk("coinc.settled", 32'(settled), 32'd1);
    chk("coinc.timeout", 32'(timeout), 32'd0);
    chk("coinc.cycles", 32'(settle_cycles), 32'(TMO));

    step(1, 1.0, "midrst_start");
    repeat (5) step(0, 0.0005, "midrst_track");
    #2 rst = 1'b1;
    #1 check_zero("midrst_async");
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(99) == 0) begin
        #2 rst = 1'b1;
        #1 check_zero("rand_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
      end
      step(($urandom_range(15) == 0), pool[$urandom_range(11)], "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
